// File: rtl/triangle_pkg.sv
// triangle_pkg: shared types and defaults for triangle_loader.
// Holds the loader FSM state enum and default widths.
package triangle_pkg;

   localparam int W_DEFAULT     = 8;
   localparam int CNT_W_DEFAULT = 16;

   typedef enum logic [2:0] {
      LOAD_A,
      LOAD_B,
      LOAD_C,
      EVAL,
      HOLD
   } ld_state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
// Ports: clk, rst_n (async low), inc, clr (sync, wins), q.
module sat_counter
   import triangle_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/triangle_loader.sv
// triangle_loader: groups a side stream into A/B/C triples for TRIANGLE.
// Ports: CLK/RST_N, DIN handshake, A/B/C, TRI_OUT, result port, counters, CLR.
module triangle_loader
   import triangle_pkg::*;
#(
   parameter int W     = W_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [W-1:0]     DIN,
   input  logic             DIN_VALID,
   output logic             DIN_READY,
   output logic [W-1:0]     A,
   output logic [W-1:0]     B,
   output logic [W-1:0]     C,
   input  logic             TRI_OUT,
   output logic             RES_VALID,
   input  logic             RES_READY,
   output logic             RES_IS_TRI,
   output logic [CNT_W-1:0] TRI_COUNT,
   output logic [CNT_W-1:0] SET_COUNT,
   input  logic             CLR
);

   ld_state_t state;
   logic      accept;
   logic      eval;

   // Ready is a pure state decode so no input reaches an output.
   assign DIN_READY = (state == LOAD_A) ||
                      (state == LOAD_B) ||
                      (state == LOAD_C);
   assign accept    = DIN_VALID & DIN_READY;
   assign eval      = (state == EVAL);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= LOAD_A;
         A          <= '0;
         B          <= '0;
         C          <= '0;
         RES_VALID  <= 1'b0;
         RES_IS_TRI <= 1'b0;
      end else begin
         unique case (state)
            LOAD_A: begin
               if (accept) begin
                  A     <= DIN;
                  state <= LOAD_B;
               end
            end
            LOAD_B: begin
               if (accept) begin
                  B     <= DIN;
                  state <= LOAD_C;
               end
            end
            LOAD_C: begin
               if (accept) begin
                  C     <= DIN;
                  state <= EVAL;
               end
            end
            // A/B/C settled for a full cycle; sample the checker.
            EVAL: begin
               RES_IS_TRI <= TRI_OUT;
               RES_VALID  <= 1'b1;
               state      <= HOLD;
            end
            HOLD: begin
               if (RES_READY) begin
                  RES_VALID <= 1'b0;
                  state     <= LOAD_A;
               end
            end
            default: begin
               state <= LOAD_A;
            end
         endcase
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_set_cnt (
      .clk   (CLK),
      .rst_n (RST_N),
      .inc   (eval),
      .clr   (CLR),
      .q     (SET_COUNT)
   );

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_tri_cnt (
      .clk   (CLK),
      .rst_n (RST_N),
      .inc   (eval & TRI_OUT),
      .clr   (CLR),
      .q     (TRI_COUNT)
   );

endmodule

// File: tb/tb_triangle_loader.sv
// tb_triangle_loader: scoreboard bench with a TRIANGLE model in the loop.
// A narrow-counter twin instance exercises saturation cheaply.
module tb_triangle_loader;
   import triangle_pkg::*;

   localparam int W     = W_DEFAULT;
   localparam int CNT_W = CNT_W_DEFAULT;
   localparam int SW    = 3;
   localparam int MAXM  = (1 << CNT_W) - 1;
   localparam int MAXS  = (1 << SW) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [W-1:0]     din = '0;
   logic             din_valid = 1'b0;
   logic             res_ready = 1'b0;
   logic             clr = 1'b0;

   logic             din_ready, res_valid, res_is_tri, tri_out;
   logic [W-1:0]     a, b, c;
   logic [CNT_W-1:0] tri_count, set_count;

   logic             s_din_ready, s_res_valid, s_res_is_tri, s_tri_out;
   logic [W-1:0]     s_a, s_b, s_c;
   logic [SW-1:0]    s_tri_count, s_set_count;

   always #5 clk = ~clk;

   function automatic logic tri_ok(input int x, input int y, input int z);
      return (x + y > z) && (x + z > y) && (y + z > x);
   endfunction

   assign tri_out   = tri_ok(int'(a), int'(b), int'(c));
   assign s_tri_out = tri_ok(int'(s_a), int'(s_b), int'(s_c));

   triangle_loader #(.W(W), .CNT_W(CNT_W)) dut (
      .CLK(clk), .RST_N(rst_n), .DIN(din), .DIN_VALID(din_valid),
      .DIN_READY(din_ready), .A(a), .B(b), .C(c), .TRI_OUT(tri_out),
      .RES_VALID(res_valid), .RES_READY(res_ready),
      .RES_IS_TRI(res_is_tri), .TRI_COUNT(tri_count),
      .SET_COUNT(set_count), .CLR(clr)
   );

   triangle_loader #(.W(W), .CNT_W(SW)) dut_s (
      .CLK(clk), .RST_N(rst_n), .DIN(din), .DIN_VALID(din_valid),
      .DIN_READY(s_din_ready), .A(s_a), .B(s_b), .C(s_c),
      .TRI_OUT(s_tri_out), .RES_VALID(s_res_valid),
      .RES_READY(res_ready), .RES_IS_TRI(s_res_is_tri),
      .TRI_COUNT(s_tri_count), .SET_COUNT(s_set_count), .CLR(clr)
   );

   typedef struct {
      int a, b, c;
      bit is_t;
      int set_c, tri_c, sset, stri;
   } exp_t;

   exp_t q[$];
   int   passed = 0;
   int   total = 0;
   int   m_set = 0, m_tri = 0, ms_set = 0, ms_tri = 0;
   bit   hold_off = 1'b0;
   bit   rand_ready = 1'b0;

   task automatic chk(input string name, input longint act,
                      input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   // Result consumer: acts 2 time units after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (hold_off) res_ready = 1'b0;
         else if (rand_ready) res_ready = 1'($urandom_range(0, 1));
         else res_ready = 1'b1;
      end
   end

   // Monitor: a result is consumed when valid and ready meet.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && res_valid && res_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               e = q.pop_front();
               chk("res_is_tri", res_is_tri, e.is_t);
               chk("abc", {a, b, c}, {W'(e.a), W'(e.b), W'(e.c)});
               chk("set_count", set_count, e.set_c);
               chk("tri_count", tri_count, e.tri_c);
               chk("s_res_valid", s_res_valid, 1);
               chk("s_res_is_tri", s_res_is_tri, e.is_t);
               chk("s_set_count", s_set_count, e.sset);
               chk("s_tri_count", s_tri_count, e.stri);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic send_byte(input int v, input bit gaps);
      int  n;
      bit  done;
      n    = 0;
      done = 1'b0;
      din  = W'(v);
      while (!done) begin
         din_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         done = din_valid && din_ready;
         @(posedge clk);
         #1;
         n++;
         if (!done && n > 300) begin
            chk("din_accept_timeout", 0, 1);
            done = 1'b1;
         end
      end
   endtask

   // Called right after the C accept edge, i.e. during EVAL.
   task automatic finish_triple(input int x, input int y, input int z,
                                input bit do_clr);
      exp_t e;
      bit   t;
      t = tri_ok(x, y, z);
      chk("eval_not_ready", din_ready, 0);
      if (do_clr) begin
         clr = 1'b1;
         m_set = 0; m_tri = 0; ms_set = 0; ms_tri = 0;
      end else begin
         m_set  = sat(m_set + 1, MAXM);
         m_tri  = sat(m_tri + int'(t), MAXM);
         ms_set = sat(ms_set + 1, MAXS);
         ms_tri = sat(ms_tri + int'(t), MAXS);
      end
      e = '{x, y, z, t, m_set, m_tri, ms_set, ms_tri};
      q.push_back(e);
      if (do_clr) begin
         @(posedge clk);
         #1;
         clr = 1'b0;
      end
   endtask

   task automatic run_triple(input int x, input int y, input int z,
                             input bit gaps, input bit do_clr);
      send_byte(x, gaps);
      send_byte(y, gaps);
      send_byte(z, gaps);
      finish_triple(x, y, z, do_clr);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain", q.size(), 0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_abc"}, {a, b, c}, 0);
      chk({tag, "_res"}, {res_valid, res_is_tri}, 0);
      chk({tag, "_cnt"}, {tri_count, set_count}, 0);
      chk({tag, "_ready"}, din_ready, 1);
      chk({tag, "_s_cnt"}, {s_tri_count, s_set_count}, 0);
   endtask

   task automatic rand_triple(output int x, output int y, output int z);
      if ($urandom_range(0, 1) == 1) begin
         x = $urandom_range(1, 200);
         y = $urandom_range(1, 200);
         z = sat($urandom_range((x > y ? x - y : y - x) + 1, x + y - 1), 255);
      end else begin
         x = $urandom_range(0, 255);
         y = $urandom_range(0, 255);
         z = $urandom_range(0, 255);
      end
   endtask

   initial begin
      int x, y, z;

      #2;
      check_reset_values("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Basic triple with result latency check.
      run_triple(3, 4, 5, 1'b0, 1'b0);
      chk("latency_before", res_valid, 0);
      @(posedge clk);
      #1;
      chk("latency_after", res_valid, 1);
      wait_drain();

      // Reset between B and C accepts.
      send_byte(9, 1'b0);
      send_byte(9, 1'b0);
      din_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      m_set = 0; m_tri = 0; ms_set = 0; ms_tri = 0;
      #1;
      check_reset_values("midreset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_triple(6, 8, 10, 1'b0, 1'b0);
      wait_drain();

      // Boundary triples back-to-back.
      run_triple(10, 100, 255, 1'b0, 1'b0);
      run_triple(1, 1, 1, 1'b0, 1'b0);
      run_triple(1, 127, 255, 1'b0, 1'b0);
      run_triple(0, 128, 127, 1'b0, 1'b0);
      run_triple(255, 128, 128, 1'b0, 1'b0);
      din_valid = 1'b0;
      wait_drain();

      // Gappy DIN_VALID and random RES_READY.
      rand_ready = 1'b1;
      run_triple(3, 4, 5, 1'b1, 1'b0);
      din_valid = 1'b0;
      wait_drain();
      rand_ready = 1'b0;

      // Back-pressure on the result port.
      hold_off = 1'b1;
      run_triple(3, 4, 5, 1'b0, 1'b0);
      din = W'(7);
      din_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("hold_ready", din_ready, 0);
         chk("hold_abc", {a, b, c}, {W'(3), W'(4), W'(5)});
         chk("hold_res", {res_valid, res_is_tri}, 3);
      end
      hold_off = 1'b0;
      send_byte(7, 1'b0);
      chk("a_after_hold", a, 7);
      send_byte(20, 1'b0);
      send_byte(25, 1'b0);
      finish_triple(7, 20, 25, 1'b0);
      din_valid = 1'b0;
      wait_drain();

      // Random traffic; narrow counters saturate here.
      rand_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         rand_triple(x, y, z);
         if (i % 2 == 0) begin
            x = $urandom_range(1, 255);
            y = x;
            z = x;
         end
         run_triple(x, y, z, 1'b1, 1'b0);
      end
      din_valid = 1'b0;
      wait_drain();
      chk("s_set_saturated", s_set_count, MAXS);
      chk("s_tri_saturated", s_tri_count, MAXS);

      // CLR during EVAL of a valid triangle beats the increment.
      run_triple(3, 4, 5, 1'b1, 1'b1);
      din_valid = 1'b0;
      wait_drain();
      chk("clr_set", set_count, 0);
      chk("clr_tri", tri_count, 0);

      for (int i = 0; i < 6; i++) begin
         rand_triple(x, y, z);
         run_triple(x, y, z, 1'b1, 1'b0);
      end
      din_valid = 1'b0;
      wait_drain();
      rand_ready = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
